// File: rtl/iob_cache_axi_write_arbiter.sv
// Round-robin arbiter that serialises whole AXI4 write transactions (AW, W burst, B)
// from N cache write channels onto one memory-side write port.
module iob_cache_axi_write_arbiter #(
  parameter int N          = 2,
  parameter int AXI_ID_W   = 1,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [N*AXI_ID_W-1:0]       s_axi_awid_i,
  input  logic [N*AXI_ADDR_W-1:0]     s_axi_awaddr_i,
  input  logic [N*AXI_LEN_W-1:0]      s_axi_awlen_i,
  input  logic [N*3-1:0]              s_axi_awsize_i,
  input  logic [N*2-1:0]              s_axi_awburst_i,
  input  logic [N-1:0]                s_axi_awvalid_i,
  output logic [N-1:0]                s_axi_awready_o,
  input  logic [N*AXI_DATA_W-1:0]     s_axi_wdata_i,
  input  logic [N*AXI_DATA_W/8-1:0]   s_axi_wstrb_i,
  input  logic [N-1:0]                s_axi_wvalid_i,
  output logic [N-1:0]                s_axi_wready_o,
  output logic [N*2-1:0]              s_axi_bresp_o,
  output logic [N-1:0]                s_axi_bvalid_o,
  input  logic [N-1:0]                s_axi_bready_i,
  output logic [AXI_ID_W-1:0]         m_axi_awid_o,
  output logic [AXI_ADDR_W-1:0]       m_axi_awaddr_o,
  output logic [AXI_LEN_W-1:0]        m_axi_awlen_o,
  output logic [2:0]                  m_axi_awsize_o,
  output logic [1:0]                  m_axi_awburst_o,
  output logic [1:0]                  m_axi_awlock_o,
  output logic [3:0]                  m_axi_awcache_o,
  output logic [2:0]                  m_axi_awprot_o,
  output logic [3:0]                  m_axi_awqos_o,
  output logic                        m_axi_awvalid_o,
  input  logic                        m_axi_awready_i,
  output logic [AXI_DATA_W-1:0]       m_axi_wdata_o,
  output logic [AXI_DATA_W/8-1:0]     m_axi_wstrb_o,
  output logic                        m_axi_wlast_o,
  output logic                        m_axi_wvalid_o,
  input  logic                        m_axi_wready_i,
  input  logic [AXI_ID_W-1:0]         m_axi_bid_i,
  input  logic [1:0]                  m_axi_bresp_i,
  input  logic                        m_axi_bvalid_i,
  output logic                        m_axi_bready_o
);

  localparam int IDX_W  = $clog2(N);
  localparam int STRB_W = AXI_DATA_W / 8;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     prio_q, prio_d;
  logic [AXI_LEN_W-1:0] len_q, len_d;
  logic [AXI_LEN_W-1:0] beat_q, beat_d;

  logic [N-1:0]         gnt_oh;
  logic [31:0]          g_idx;
  logic                 sel_wvalid;
  logic                 sel_bready;
  logic                 w_hs;
  logic                 b_hs;

  // Response routing relies solely on the registered grant, so the B id is not consumed.
  logic                 bid_unused;
  assign bid_unused = ^m_axi_bid_i;

  assign gnt_oh     = N'(1) << grant_q;
  assign g_idx      = 32'(grant_q);
  assign sel_wvalid = |(s_axi_wvalid_i & gnt_oh);
  assign sel_bready = |(s_axi_bready_i & gnt_oh);
  assign w_hs       = (state_q == ST_DATA) && sel_wvalid && m_axi_wready_i;
  assign b_hs       = (state_q == ST_RESP) && m_axi_bvalid_i && sel_bready;

  logic             found;
  logic [IDX_W-1:0] sel;
  logic [31:0]      idx;
  logic [N-1:0]     req_sh;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    len_d   = len_q;
    beat_d  = beat_q;
    found   = 1'b0;
    sel     = '0;
    idx     = '0;
    req_sh  = '0;
    case (state_q)
      ST_IDLE: begin
        // Rotating search starting at prio; first hit wins.
        for (int unsigned i = 0; i < N; i++) begin
          idx    = (32'(prio_q) + i) % N;
          req_sh = s_axi_awvalid_i >> idx;
          if (!found && req_sh[0]) begin
            found = 1'b1;
            sel   = IDX_W'(idx);
          end
        end
        if (found) begin
          grant_d = sel;
          len_d   = s_axi_awlen_i[32'(sel)*AXI_LEN_W +: AXI_LEN_W];
          beat_d  = '0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_axi_awready_i) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (w_hs) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == len_q) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (b_hs) begin
          prio_d  = (grant_q == IDX_W'(N - 1)) ? '0 : grant_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      prio_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
    end
  end

  assign m_axi_awlock_o  = '0;
  assign m_axi_awcache_o = 4'b0011;
  assign m_axi_awprot_o  = '0;
  assign m_axi_awqos_o   = '0;

  // Payloads are gated to the phase that owns them so idle/reset outputs stay at zero.
  always_comb begin
    s_axi_awready_o = '0;
    s_axi_wready_o  = '0;
    s_axi_bvalid_o  = '0;
    s_axi_bresp_o   = '0;
    m_axi_awid_o    = '0;
    m_axi_awaddr_o  = '0;
    m_axi_awlen_o   = '0;
    m_axi_awsize_o  = '0;
    m_axi_awburst_o = '0;
    m_axi_awvalid_o = 1'b0;
    m_axi_wdata_o   = '0;
    m_axi_wstrb_o   = '0;
    m_axi_wlast_o   = 1'b0;
    m_axi_wvalid_o  = 1'b0;
    m_axi_bready_o  = 1'b0;
    case (state_q)
      ST_ADDR: begin
        m_axi_awvalid_o = 1'b1;
        m_axi_awid_o    = s_axi_awid_i[g_idx*AXI_ID_W +: AXI_ID_W];
        m_axi_awaddr_o  = s_axi_awaddr_i[g_idx*AXI_ADDR_W +: AXI_ADDR_W];
        m_axi_awlen_o   = s_axi_awlen_i[g_idx*AXI_LEN_W +: AXI_LEN_W];
        m_axi_awsize_o  = s_axi_awsize_i[g_idx*3 +: 3];
        m_axi_awburst_o = s_axi_awburst_i[g_idx*2 +: 2];
        s_axi_awready_o = gnt_oh & {N{m_axi_awready_i}};
      end
      ST_DATA: begin
        m_axi_wvalid_o  = sel_wvalid;
        m_axi_wdata_o   = s_axi_wdata_i[g_idx*AXI_DATA_W +: AXI_DATA_W];
        m_axi_wstrb_o   = s_axi_wstrb_i[g_idx*STRB_W +: STRB_W];
        m_axi_wlast_o   = sel_wvalid && (beat_q == len_q);
        s_axi_wready_o  = gnt_oh & {N{m_axi_wready_i}};
      end
      ST_RESP: begin
        m_axi_bready_o  = sel_bready;
        s_axi_bvalid_o  = gnt_oh & {N{m_axi_bvalid_i}};
        s_axi_bresp_o   = {N{m_axi_bresp_i}};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_iob_cache_axi_write_arbiter.sv
// Directed bench for iob_cache_axi_write_arbiter with two requesters.
module tb_iob_cache_axi_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  awid;
  logic [63:0] awaddr;
  logic [15:0] awlen;
  logic [5:0]  awsize;
  logic [3:0]  awburst;
  logic [1:0]  awvalid, awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic [1:0]  wvalid, wready;
  logic [3:0]  s_bresp;
  logic [1:0]  s_bvalid, bready;
  logic [0:0]  m_awid;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst, m_awlock;
  logic [3:0]  m_awcache, m_awqos;
  logic [2:0]  m_awprot;
  logic        m_awvalid, m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast, m_wvalid, m_wready;
  logic [0:0]  m_bid;
  logic [1:0]  m_bresp;
  logic        m_bvalid, m_bready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  iob_cache_axi_write_arbiter #(.N(2), .AXI_ID_W(1), .AXI_ADDR_W(32), .AXI_DATA_W(32), .AXI_LEN_W(8)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .s_axi_awid_i(awid), .s_axi_awaddr_i(awaddr), .s_axi_awlen_i(awlen),
    .s_axi_awsize_i(awsize), .s_axi_awburst_i(awburst), .s_axi_awvalid_i(awvalid),
    .s_axi_awready_o(awready), .s_axi_wdata_i(wdata), .s_axi_wstrb_i(wstrb),
    .s_axi_wvalid_i(wvalid), .s_axi_wready_o(wready), .s_axi_bresp_o(s_bresp),
    .s_axi_bvalid_o(s_bvalid), .s_axi_bready_i(bready),
    .m_axi_awid_o(m_awid), .m_axi_awaddr_o(m_awaddr), .m_axi_awlen_o(m_awlen),
    .m_axi_awsize_o(m_awsize), .m_axi_awburst_o(m_awburst), .m_axi_awlock_o(m_awlock),
    .m_axi_awcache_o(m_awcache), .m_axi_awprot_o(m_awprot), .m_axi_awqos_o(m_awqos),
    .m_axi_awvalid_o(m_awvalid), .m_axi_awready_i(m_awready),
    .m_axi_wdata_o(m_wdata), .m_axi_wstrb_o(m_wstrb), .m_axi_wlast_o(m_wlast),
    .m_axi_wvalid_o(m_wvalid), .m_axi_wready_i(m_wready),
    .m_axi_bid_i(m_bid), .m_axi_bresp_i(m_bresp), .m_axi_bvalid_i(m_bvalid),
    .m_axi_bready_o(m_bready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic raise(input int r, input logic [31:0] addr, input logic [7:0] len);
    awaddr[r*32 +: 32] = addr;
    awlen[r*8 +: 8]    = len;
    awid[r]            = 1'(r);
    awsize[r*3 +: 3]   = 3'd2;
    awburst[r*2 +: 2]  = 2'b01;
    awvalid[r]         = 1'b1;
  endtask

  // Drives one complete transaction for requester r, starting from IDLE.
  task automatic run_txn(input int r, input logic [31:0] addr, input logic [7:0] len,
                         input int aw_stall, input bit toggle, input logic [1:0] resp);
    int          beat;
    logic [1:0]  oh;
    logic [31:0] d;
    logic [3:0]  s;
    oh = 2'b01 << r;
    raise(r, addr, len);
    m_awready = 1'b0;
    #1;
    chk("idle_m_awvalid", m_awvalid, 0);
    chk("idle_s_awready", awready, 0);
    tick();
    for (int c = 0; c < aw_stall; c++) begin
      #1;
      chk("stall_m_awvalid", m_awvalid, 1);
      chk("stall_m_awaddr", m_awaddr, addr);
      chk("stall_s_awready", awready, 0);
      tick();
    end
    m_awready = 1'b1;
    #1;
    chk("addr_m_awvalid", m_awvalid, 1);
    chk("addr_m_awaddr", m_awaddr, addr);
    chk("addr_m_awlen", m_awlen, len);
    chk("addr_m_awid", m_awid, r);
    chk("addr_m_awsize", m_awsize, 2);
    chk("addr_m_awburst", m_awburst, 1);
    chk("addr_s_awready", awready, oh);
    chk("addr_m_wvalid", m_wvalid, 0);
    chk("addr_s_wready", wready, 0);
    tick();
    awvalid[r] = 1'b0;
    m_awready  = 1'b0;
    beat = 0;
    for (int c = 0; c < 64 && beat <= int'(len); c++) begin
      m_wready = toggle ? ((c % 2) == 0) : 1'b1;
      d = 32'hA000_0000 | (r << 16) | (addr[11:8] << 8) | beat;
      s = 4'hF ^ 4'(beat);
      wdata[r*32 +: 32] = d;
      wstrb[r*4 +: 4]   = s;
      wvalid[r]         = 1'b1;
      #1;
      chk("data_m_wvalid", m_wvalid, 1);
      chk("data_m_wdata", m_wdata, d);
      chk("data_m_wstrb", m_wstrb, s);
      chk("data_m_wlast", m_wlast, (beat == int'(len)));
      chk("data_s_wready", wready, m_wready ? oh : 2'b00);
      chk("data_m_awvalid", m_awvalid, 0);
      tick();
      if (m_wready) beat++;
    end
    chk("beat_count", beat, int'(len) + 1);
    wvalid[r] = 1'b0;
    m_wready  = 1'b0;
    #1;
    chk("resp_m_wvalid", m_wvalid, 0);
    chk("resp_m_wlast", m_wlast, 0);
    chk("resp_s_bvalid_idle", s_bvalid, 0);
    m_bvalid  = 1'b1;
    m_bresp   = resp;
    m_bid     = 1'(r);
    bready[r] = 1'b1;
    #1;
    chk("resp_s_bvalid", s_bvalid, oh);
    chk("resp_m_bready", m_bready, 1);
    chk("resp_s_bresp", s_bresp, {resp, resp});
    tick();
    m_bvalid  = 1'b0;
    m_bresp   = 2'b00;
    bready[r] = 1'b0;
    #1;
    chk("post_m_awvalid", m_awvalid, 0);
    chk("post_s_bvalid", s_bvalid, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = '0;
    wdata = '0; wstrb = '0; wvalid = '0; bready = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
    #3;
    chk("rst_m_awvalid", m_awvalid, 0);
    chk("rst_m_wvalid", m_wvalid, 0);
    chk("rst_m_bready", m_bready, 0);
    chk("rst_s_awready", awready, 0);
    chk("rst_m_awcache", m_awcache, 4'b0011);
    chk("rst_m_awlock", m_awlock, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single request from requester 1.
    run_txn(1, 32'h100, 8'd3, 0, 1'b0, 2'b00);

    // Contention: both request together; 0 wins, 1 next, third from 0 waits.
    raise(1, 32'h200, 8'd1);
    run_txn(0, 32'h180, 8'd2, 0, 1'b0, 2'b00);
    raise(0, 32'h300, 8'd2);
    wvalid[0] = 1'b1;
    wdata[31:0] = 32'hDEAD_BEEF;
    run_txn(1, 32'h200, 8'd1, 0, 1'b0, 2'b00);
    // Backpressure on the third transaction.
    run_txn(0, 32'h300, 8'd3, 5, 1'b1, 2'b00);

    // Reset mid-burst while prio points at requester 1.
    raise(1, 32'h400, 8'd3);
    tick();
    m_awready = 1'b1;
    tick();
    m_awready = 1'b0;
    wvalid[1] = 1'b1;
    wdata[63:32] = 32'h11;
    m_wready = 1'b1;
    tick();
    wdata[63:32] = 32'h22;
    #1;
    chk("prerst_m_wvalid", m_wvalid, 1);
    chk("prerst_m_wdata", m_wdata, 32'h22);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_m_wvalid", m_wvalid, 0);
    chk("midrst_s_wready", wready, 0);
    chk("midrst_m_wdata", m_wdata, 0);
    chk("midrst_m_wlast", m_wlast, 0);
    chk("midrst_m_awvalid", m_awvalid, 0);
    chk("midrst_m_bready", m_bready, 0);
    wvalid = '0;
    m_wready = 1'b0;
    raise(0, 32'h500, 8'd1);
    tick();
    rst_n = 1'b1;
    run_txn(0, 32'h500, 8'd1, 0, 1'b0, 2'b00);
    run_txn(1, 32'h400, 8'd3, 0, 1'b0, 2'b00);

    // Error response on requester 0, then prio must favour requester 1.
    run_txn(0, 32'h600, 8'd0, 0, 1'b0, 2'b10);
    raise(0, 32'h700, 8'd0);
    run_txn(1, 32'h800, 8'd1, 1, 1'b1, 2'b11);
    run_txn(0, 32'h700, 8'd0, 0, 1'b0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
